// File: rtl/sdram_arbiter.sv
// sdram_arbiter: front end that lets NUM_REQ masters share the single SoC-side
// port of sdram_controller. One access is in flight at a time. Each access is
// sequenced through the controller's busy/ready handshake, and completion is
// returned to the winning requester as a one-cycle ack.
// Optional feature macro: SDRAM_ARB_FIXED_PRIO_EN. When it is defined,
// requester 0 has strict priority and the remaining requesters rotate among
// themselves. When it is undefined, all requesters are served round-robin.
module sdram_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             reset_n_port,
  input  logic [NUM_REQ-1:0]               req_valid_port,
  input  logic [NUM_REQ-1:0]               req_we_port,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_port,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wr_data_port,
  input  logic [NUM_REQ*MASK_WIDTH-1:0]    req_wr_mask_port,
  output logic [NUM_REQ-1:0]               req_ack_port,
  output logic [DATA_WIDTH-1:0]            req_rd_data_port,
  input  logic                             ctl_busy_port,
  input  logic                             ctl_ready_port,
  output logic [ADDR_WIDTH-1:0]            ctl_addr_port,
  output logic [DATA_WIDTH-1:0]            ctl_wr_data_port,
  output logic [MASK_WIDTH-1:0]            ctl_wr_mask_port,
  output logic                             ctl_wr_en_port,
  output logic                             ctl_rd_en_port,
  input  logic [DATA_WIDTH-1:0]            ctl_rd_data_port
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      last_granted;
  logic                  we;

  logic                  any_valid;
  logic [IDX_W-1:0]      winner;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [MASK_WIDTH-1:0] sel_mask;
  int                    best_d;
  int                    d;

  // Pick the pending requester closest after last_granted in rotation order
  // (distance 0 is last_granted+1) and mux out its request fields.
  always_comb begin
    any_valid = |req_valid_port;
    winner    = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_mask  = '0;
    best_d    = NUM_REQ;
    d         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid_port[i]) begin
        d = i - int'(last_granted) - 1;
        if (d < 0) d = d + NUM_REQ;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        // Requester 0 beats any rotation distance whenever it asks.
        if (i == 0) d = -1;
`endif
        if (d < best_d) begin
          best_d   = d;
          winner   = IDX_W'(i);
          sel_we   = req_we_port[i];
          sel_addr = req_addr_port[i*ADDR_WIDTH +: ADDR_WIDTH];
          sel_data = req_wr_data_port[i*DATA_WIDTH +: DATA_WIDTH];
          sel_mask = req_wr_mask_port[i*MASK_WIDTH +: MASK_WIDTH];
        end
      end
    end
  end

  // Access sequencer: grant, one-cycle enable, busy/ready handshake, ack.
  always_ff @(posedge clk or negedge reset_n_port) begin
    if (!reset_n_port) begin
      state            <= IDLE;
      idx              <= '0;
      last_granted     <= IDX_W'(NUM_REQ - 1);
      we               <= 1'b0;
      ctl_addr_port    <= '0;
      ctl_wr_data_port <= '0;
      ctl_wr_mask_port <= '0;
      ctl_wr_en_port   <= 1'b0;
      ctl_rd_en_port   <= 1'b0;
      req_ack_port     <= '0;
      req_rd_data_port <= '0;
    end else begin
      ctl_wr_en_port <= 1'b0;
      ctl_rd_en_port <= 1'b0;
      req_ack_port   <= '0;
      case (state)
        IDLE: begin
          // A busy controller (init or refresh) holds off every grant.
          if (any_valid && !ctl_busy_port) begin
            idx              <= winner;
            we               <= sel_we;
            ctl_addr_port    <= sel_addr;
            ctl_wr_data_port <= sel_data;
            ctl_wr_mask_port <= sel_mask;
            ctl_wr_en_port   <= sel_we;
            ctl_rd_en_port   <= !sel_we;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          // The enable drops by default here, so it is high for exactly one cycle.
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (ctl_busy_port) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (we) begin
            if (!ctl_busy_port) begin
              req_ack_port <= NUM_REQ'(1) << idx;
              state        <= DONE;
            end
          end else if (ctl_ready_port) begin
            req_rd_data_port <= ctl_rd_data_port;
            req_ack_port     <= NUM_REQ'(1) << idx;
            state            <= DONE;
          end
        end
        DONE: begin
          // Rotation restarts after the requester just served.
          last_granted <= idx;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small behavioural model of the
// sdram_controller busy/ready handshake.
module tb_sdram_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [45:0] req_addr;
  logic [63:0] req_wr_data;
  logic [7:0]  req_wr_mask;
  logic [1:0]  req_ack;
  logic [31:0] req_rd_data;
  logic        ctl_busy;
  logic        ctl_ready;
  logic [22:0] ctl_addr;
  logic [31:0] ctl_wr_data;
  logic [3:0]  ctl_wr_mask;
  logic        ctl_wr_en;
  logic        ctl_rd_en;
  logic [31:0] ctl_rd_data;

  sdram_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(23), .DATA_WIDTH(32), .MASK_WIDTH(4)
  ) dut (
    .clk              (clk),
    .reset_n_port     (reset_n),
    .req_valid_port   (req_valid),
    .req_we_port      (req_we),
    .req_addr_port    (req_addr),
    .req_wr_data_port (req_wr_data),
    .req_wr_mask_port (req_wr_mask),
    .req_ack_port     (req_ack),
    .req_rd_data_port (req_rd_data),
    .ctl_busy_port    (ctl_busy),
    .ctl_ready_port   (ctl_ready),
    .ctl_addr_port    (ctl_addr),
    .ctl_wr_data_port (ctl_wr_data),
    .ctl_wr_mask_port (ctl_wr_mask),
    .ctl_wr_en_port   (ctl_wr_en),
    .ctl_rd_en_port   (ctl_rd_en),
    .ctl_rd_data_port (ctl_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: busy for a few cycles per access, ready pulse on reads.
  logic        init_busy;
  logic        m_busy;
  logic        m_we;
  logic [2:0]  m_cnt;
  logic [22:0] m_addr;

  function automatic logic [31:0] rd_word(input logic [22:0] a);
    if (a == 23'h7FFFFF) return 32'h12345678;
    return {8'hC0, 1'b0, a};
  endfunction

  assign ctl_busy = m_busy | init_busy;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_we <= 1'b0; m_cnt <= '0; m_addr <= '0;
      ctl_ready <= 1'b0; ctl_rd_data <= '0;
    end else begin
      ctl_ready <= 1'b0;
      if (!m_busy) begin
        if (ctl_wr_en || ctl_rd_en) begin
          m_busy <= 1'b1; m_cnt <= 3'd3; m_we <= ctl_wr_en; m_addr <= ctl_addr;
        end
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 3'd1;
      end else begin
        m_busy <= 1'b0;
        if (!m_we) begin
          ctl_ready   <= 1'b1;
          ctl_rd_data <= rd_word(m_addr);
        end
      end
    end
  end

  int          n_total = 0;
  int          n_bad   = 0;
  int          n_wr = 0, n_rd = 0, n_ack = 0, n_overlap = 0, n_long = 0;
  logic        prev_wr = 1'b0, prev_rd = 1'b0;
  logic [22:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic [1:0]  ack_vec [64];
  logic [31:0] ack_dat [64];
  logic [1:0]  exp_vec [5];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; samples outputs on the falling edge and logs events.
  task automatic tick();
    @(negedge clk);
    if (ctl_wr_en) begin
      n_wr++; wr_addr = ctl_addr; wr_data = ctl_wr_data; wr_mask = ctl_wr_mask;
    end
    if (ctl_rd_en) n_rd++;
    if ((ctl_wr_en && prev_wr) || (ctl_rd_en && prev_rd)) n_long++;
    prev_wr = ctl_wr_en; prev_rd = ctl_rd_en;
    if (req_ack != 2'b00) begin
      if (n_ack < 64) begin
        ack_vec[n_ack] = req_ack; ack_dat[n_ack] = req_rd_data;
      end
      n_ack++;
      if (ctl_wr_en || ctl_rd_en) n_overlap++;
    end
  endtask

  task automatic wait_ack(input string tag, input int target, input int limit);
    int c = 0;
    while (n_ack < target && c < limit) begin
      tick();
      c++;
    end
    check_eq({tag, "_ack_seen"}, 64'(n_ack >= target), 64'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = 2'b00;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Both requesters read continuously; each drops after its quota of acks.
  task automatic rr_run(input string tag, input int t0, input int t1);
    int c0 = 0, c1 = 0, n = 0;
    req_we    = 2'b00;
    req_addr  = {23'h000300, 23'h000200};
    req_valid = 2'b11;
    while ((c0 < t0 || c1 < t1) && n < 400) begin
      tick();
      n++;
      if (req_ack[0]) begin c0++; if (c0 >= t0) req_valid[0] = 1'b0; end
      if (req_ack[1]) begin c1++; if (c1 >= t1) req_valid[1] = 1'b0; end
    end
    check_eq({tag, "_complete"}, 64'(c0 >= t0 && c1 >= t1), 64'd1);
  endtask

  initial begin
    int base;
    int cw;
    reset_n     = 1'b1;
    init_busy   = 1'b1;
    req_valid   = 2'b00;
    req_we      = 2'b00;
    req_addr    = '0;
    req_wr_data = '0;
    req_wr_mask = '0;
    #2 reset_n = 1'b0;
    tick(); tick();

    check_eq("rst_ack",     64'(req_ack),     64'h0);
    check_eq("rst_wr_en",   64'(ctl_wr_en),   64'h0);
    check_eq("rst_rd_en",   64'(ctl_rd_en),   64'h0);
    check_eq("rst_addr",    64'(ctl_addr),    64'h0);
    check_eq("rst_wr_data", 64'(ctl_wr_data), 64'h0);
    check_eq("rst_wr_mask", 64'(ctl_wr_mask), 64'h0);
    check_eq("rst_rd_data", 64'(req_rd_data), 64'h0);

    // Write from requester 0 held off while the controller is initialising.
    reset_n = 1'b1;
    req_we      = 2'b01;
    req_addr    = {23'h0, 23'h000100};
    req_wr_data = {32'h0, 32'hDEADBEEF};
    req_wr_mask = 8'h00;
    req_valid   = 2'b01;
    base = n_ack;
    repeat (10) tick();
    check_eq("t1_no_en_while_busy", 64'(n_wr + n_rd), 64'd0);
    init_busy = 1'b0;
    wait_ack("t1", base + 1, 50);
    req_valid = 2'b00;
    repeat (4) tick();
    check_eq("t1_wr_pulses", 64'(n_wr), 64'd1);
    check_eq("t1_rd_pulses", 64'(n_rd), 64'd0);
    check_eq("t1_addr",      64'(wr_addr), 64'h000100);
    check_eq("t1_data",      64'(wr_data), 64'hDEADBEEF);
    check_eq("t1_mask",      64'(wr_mask), 64'h0);
    check_eq("t1_ack_vec",   64'(ack_vec[base]), 64'b01);
    check_eq("t1_ack_count", 64'(n_ack - base), 64'd1);

    // Simultaneous reads from both requesters, two accesses each.
    do_reset();
    base = n_ack;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_vec[0] = 2'b01; exp_vec[1] = 2'b01; exp_vec[2] = 2'b10; exp_vec[3] = 2'b10;
`else
    exp_vec[0] = 2'b01; exp_vec[1] = 2'b10; exp_vec[2] = 2'b01; exp_vec[3] = 2'b10;
`endif
    rr_run("t2", 2, 2);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t2_grant%0d", k), 64'(ack_vec[base + k]), 64'(exp_vec[k]));
      check_eq($sformatf("t2_data%0d", k), 64'(ack_dat[base + k]),
               (exp_vec[k] == 2'b01) ? 64'hC0000200 : 64'hC0000300);
    end

    // Read from requester 1 at the top of the address space.
    do_reset();
    base = n_ack;
    req_we    = 2'b00;
    req_addr  = {23'h7FFFFF, 23'h000055};
    req_valid = 2'b10;
    wait_ack("t3", base + 1, 50);
    req_valid = 2'b00;
    check_eq("t3_ack_vec",  64'(ack_vec[base]), 64'b10);
    check_eq("t3_ack_data", 64'(ack_dat[base]), 64'h12345678);
    // A following write must leave the read data untouched.
    req_we      = 2'b01;
    req_wr_data = {32'h0, 32'h11111111};
    req_wr_mask = 8'h0F;
    req_valid   = 2'b01;
    wait_ack("t3w", base + 2, 50);
    req_valid = 2'b00;
    tick();
    check_eq("t3w_ack_vec", 64'(ack_vec[base + 1]), 64'b01);
    check_eq("t3_rd_hold",  64'(req_rd_data), 64'h12345678);

    // Reset in the middle of a read access.
    req_we    = 2'b00;
    req_addr  = {23'h000600, 23'h000400};
    req_valid = 2'b01;
    cw = 0;
    while (!ctl_busy && cw < 20) begin tick(); cw++; end
    check_eq("t4_busy_seen", 64'(ctl_busy), 64'd1);
    tick();
    base = n_ack;
    #1 reset_n = 1'b0;
    #1;
    check_eq("t4_ack",     64'(req_ack),     64'h0);
    check_eq("t4_wr_en",   64'(ctl_wr_en),   64'h0);
    check_eq("t4_rd_en",   64'(ctl_rd_en),   64'h0);
    check_eq("t4_addr",    64'(ctl_addr),    64'h0);
    check_eq("t4_wr_data", 64'(ctl_wr_data), 64'h0);
    check_eq("t4_wr_mask", 64'(ctl_wr_mask), 64'h0);
    check_eq("t4_rd_data", 64'(req_rd_data), 64'h0);
    repeat (3) tick();
    check_eq("t4_no_ack_in_reset", 64'(n_ack - base), 64'd0);
    req_valid = 2'b11;
    reset_n   = 1'b1;
    wait_ack("t4a", base + 1, 50);
    req_valid[0] = 1'b0;
    check_eq("t4_first_vec",  64'(ack_vec[base]), 64'b01);
    check_eq("t4_first_data", 64'(ack_dat[base]), 64'hC0000400);
    wait_ack("t4b", base + 2, 50);
    req_valid = 2'b00;
    check_eq("t4_second_vec",  64'(ack_vec[base + 1]), 64'b10);
    check_eq("t4_second_data", 64'(ack_dat[base + 1]), 64'hC0000600);

    // Requester 0 kept busy with three accesses while requester 1 wants two.
    do_reset();
    base = n_ack;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_vec[0] = 2'b01; exp_vec[1] = 2'b01; exp_vec[2] = 2'b01;
    exp_vec[3] = 2'b10; exp_vec[4] = 2'b10;
`else
    exp_vec[0] = 2'b01; exp_vec[1] = 2'b10; exp_vec[2] = 2'b01;
    exp_vec[3] = 2'b10; exp_vec[4] = 2'b01;
`endif
    rr_run("t5", 3, 2);
    for (int k = 0; k < 5; k++)
      check_eq($sformatf("t5_grant%0d", k), 64'(ack_vec[base + k]), 64'(exp_vec[k]));

    repeat (4) tick();
    check_eq("ack_en_overlap", 64'(n_overlap), 64'd0);
    check_eq("en_pulse_width", 64'(n_long), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
